prog_loader: RTL and testbench

Host-side writer for the core's 9-bit instruction memory; the counterpart of the core's instruction fetch path. Accepts a stream of 9-bit machine words over a valid/ready interface and writes them to consecutive instruction-memory addresses starting at 0. Holds the core in reset while loading, then pulses start and waits for the core's done. Sits between the testbench/host and the TopLevel instance.

---
 rtl/prog_loader.sv | 116 +++++++++++
 tb/tb_prog_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: host-side writer for the core's instruction memory.
// Streams words into consecutive addresses from 0 while holding the core
// in reset, then pulses core_start and waits for core_done.
module prog_loader #(
   parameter int unsigned AW = 8,
   parameter int unsigned IW = 9,
   parameter int unsigned LW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_req,
   input  logic [LW-1:0] len,
   input  logic          in_valid,
   input  logic [IW-1:0] in_data,
   output logic          in_ready,
   output logic          im_wen,
   output logic [AW-1:0] im_addr,
   output logic [IW-1:0] im_wdata,
   output logic          core_hold,
   output logic          core_start,
   input  logic          core_done,
   output logic          busy,
   output logic [LW-1:0] loaded_count,
   output logic          err
);

   typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] count_q, count_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          err_q, err_d;
   logic          xfer;

   // Next-state and Moore/Mealy outputs for the load session
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      addr_d     = addr_q;
      err_d      = err_q;
      in_ready   = 1'b0;
      core_hold  = 1'b0;
      core_start = 1'b0;
      busy       = 1'b1;
      xfer       = 1'b0;
      case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (load_req) begin
               if (len != '0) begin
                  len_d   = len;
                  count_d = '0;
                  addr_d  = '0;
                  err_d   = 1'b0;
                  state_d = StLoad;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StLoad: begin
            in_ready  = 1'b1;
            core_hold = 1'b1;
            xfer      = in_valid;
            if (in_valid) begin
               // Address may wrap to 0 on a full image; in_ready drops so no write follows
               addr_d  = addr_q + AW'(1);
               count_d = count_q + LW'(1);
               if (count_q + LW'(1) == len_q) begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            core_start = 1'b1;
            state_d    = StRun;
         end
         StRun: begin
            if (core_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and session registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         len_q   <= '0;
         count_q <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   // Write port is combinational on a transfer; data is zeroed otherwise
   always_comb begin
      im_wen   = xfer;
      im_addr  = addr_q;
      im_wdata = xfer ? in_data : '0;
   end

   assign loaded_count = count_q;
   assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven load sessions plus hand-written corner cases,
// with a write scoreboard checked on every im_wen.
module tb_prog_loader;

   localparam int AW = 8;
   localparam int IW = 9;
   localparam int LW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_req;
   logic [LW-1:0] len;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          in_ready;
   logic          im_wen;
   logic [AW-1:0] im_addr;
   logic [IW-1:0] im_wdata;
   logic          core_hold;
   logic          core_start;
   logic          core_done;
   logic          busy;
   logic [LW-1:0] loaded_count;
   logic          err;

   prog_loader #(.AW(AW), .IW(IW), .LW(LW)) dut (
      .clk          (clk),
      .reset        (reset),
      .load_req     (load_req),
      .len          (len),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_wen       (im_wen),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .core_hold    (core_hold),
      .core_start   (core_start),
      .core_done    (core_done),
      .busy         (busy),
      .loaded_count (loaded_count),
      .err          (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      logic [LW-1:0] n;
      logic [31:0]   pat;
      bit            fixed;
      int            run_wait;
      bit            done_in_start;
   } sess_t;

   sess_t         tbl[4];
   logic [IW-1:0] fixed_words[3] = '{9'h0A3, 9'h155, 9'h1FF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every write must match the next expected {addr, data}
   always @(negedge clk) begin
      if (!reset && im_wen) begin
         wr_t e;
         checks++;
         if (!in_ready) begin
            errors++;
            $display("FAIL wen_without_ready: im_wen=1 while in_ready=0 at %0t", $time);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                     im_addr, im_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({im_addr, im_wdata} !== {e.addr, e.data}) begin
               errors++;
               $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        im_addr, im_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_im_wen"}, im_wen, 0);
      chk({tag, "_core_hold"}, core_hold, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_im_addr"}, im_addr, 0);
      chk({tag, "_im_wdata"}, im_wdata, 0);
      chk({tag, "_loaded_count"}, loaded_count, 0);
   endtask

   // One full session; entered #1 after a rising edge with the DUT in IDLE
   task automatic run_session(input sess_t s);
      int            sent;
      int            cyc;
      logic [AW-1:0] a;
      logic [IW-1:0] w;
      wr_t           e;
      load_req = 1'b1;
      len      = s.n;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
      load_req = 1'b0;
      len      = '0;
      sent     = 0;
      cyc      = 0;
      a        = '0;
      while (sent < int'(s.n) && cyc < int'(s.n) * 4 + 64) begin
         in_valid = s.pat[cyc % 32];
         w        = s.fixed ? fixed_words[sent % 3] : IW'($urandom);
         in_data  = w;
         if (in_valid) begin
            e.addr = a;
            e.data = w;
            exp_q.push_back(e);
         end
         @(negedge clk);
         chk("load_in_ready", in_ready, 1);
         chk("load_core_hold", core_hold, 1);
         chk("load_busy", busy, 1);
         chk("load_im_wen", im_wen, in_valid);
         if (cyc == 0) chk("load_count_start", loaded_count, 0);
         @(posedge clk); #1;
         if (in_valid) begin
            sent++;
            a++;
         end
         cyc++;
      end
      if (sent < int'(s.n)) begin
         checks++;
         errors++;
         $display("FAIL load_timeout: sent %0d words, required %0d", sent, s.n);
      end
      in_valid  = 1'b0;
      core_done = s.done_in_start;
      @(negedge clk);
      chk("start_pulse", core_start, 1);
      chk("start_in_ready", in_ready, 0);
      chk("start_core_hold", core_hold, 0);
      chk("start_busy", busy, 1);
      chk("start_loaded_count", loaded_count, s.n);
      chk("start_im_wen", im_wen, 0);
      @(posedge clk); #1;
      core_done = 1'b0;
      load_req  = (s.run_wait > 0);
      len       = 9'd5;
      @(negedge clk);
      chk("run_core_start", core_start, 0);
      chk("run_busy", busy, 1);
      chk("run_core_hold", core_hold, 0);
      for (int i = 0; i < s.run_wait; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("run_wait_busy", busy, 1);
         chk("run_wait_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      load_req  = 1'b0;
      len       = '0;
      core_done = 1'b1;
      @(negedge clk);
      chk("done_cycle_busy", busy, 1);
      @(posedge clk); #1;
      core_done = 1'b0;
      @(negedge clk);
      chk("after_done_busy", busy, 0);
      chk("after_done_core_hold", core_hold, 0);
      chk("after_done_loaded_count", loaded_count, s.n);
      chk("scoreboard_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("idle_hold_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{9'd3,   32'hFFFF_FFFF, 1'b1, 0,  1'b0};
      tbl[1] = '{9'd4,   32'h0000_0035, 1'b0, 0,  1'b0};
      tbl[2] = '{9'd256, 32'hFFFF_FFFF, 1'b0, 2,  1'b0};
      tbl[3] = '{9'd2,   32'hFFFF_FFFF, 1'b0, 10, 1'b1};

      reset     = 1'b1;
      load_req  = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      core_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      for (int r = 0; r < 4; r++) run_session(tbl[r]);

      // len==0 request sets err and stays idle
      load_req = 1'b1;
      len      = '0;
      @(negedge clk);
      chk("len0_err_before", err, 0);
      @(posedge clk); #1;
      load_req = 1'b0;
      @(negedge clk);
      chk("len0_err", err, 1);
      chk("len0_busy", busy, 0);
      chk("len0_in_ready", in_ready, 0);
      chk("len0_im_wen", im_wen, 0);
      @(posedge clk); #1;
      chk("len0_err_sticky", err, 1);
      run_session('{9'd1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0});
      chk("len1_err_cleared", err, 0);

      // Reset in the middle of a 5-word load
      load_req = 1'b1;
      len      = 9'd5;
      @(posedge clk); #1;
      load_req = 1'b0;
      len      = '0;
      for (int k = 0; k < 2; k++) begin
         wr_t e;
         in_valid = 1'b1;
         in_data  = IW'(9'h040 + k);
         e.addr   = AW'(k);
         e.data   = in_data;
         exp_q.push_back(e);
         @(posedge clk); #1;
      end
      chk("midload_count", loaded_count, 2);
      in_data = 9'h0F0;
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset_scoreboard", exp_q.size(), 0);
      @(posedge clk); #1;
      run_session('{9'd2, 32'hFFFF_FFFF, 1'b0, 0, 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
